// File: rtl/logic_unit_pipe.sv
// Registered WIDTH-bit universal logic unit: eight bitwise ops, optional accumulator
// feedback for operand B, single valid/ready register slice and accepted-op counter.
module logic_unit_pipe #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [2:0]       sel,
  input  logic             use_acc,
  input  logic             acc_clr,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out,
  output logic             out_zero,
  output logic             out_parity,
  output logic [WIDTH-1:0] acc,
  output logic [CNT_W-1:0] op_count
);

  logic [WIDTH-1:0] b_eff;
  logic [WIDTH-1:0] result;
  logic             accept;

  assign in_ready = !out_valid || out_ready;
  assign accept   = in_valid && in_ready;
  assign b_eff    = use_acc ? acc : b;

  // Codes 6 and 7 are both NAND so the 1-bit selector's encoding carries over.
  always_comb begin
    result = '0;
    case (sel)
      3'd0:    result = ~a;
      3'd1:    result = ~(a | b_eff);
      3'd2:    result = a & b_eff;
      3'd3:    result = a | b_eff;
      3'd4:    result = a ^ b_eff;
      3'd5:    result = ~(a ^ b_eff);
      default: result = ~(a & b_eff);
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid  <= 1'b0;
      out        <= '0;
      out_zero   <= 1'b0;
      out_parity <= 1'b0;
      op_count   <= '0;
    end else if (accept) begin
      out_valid  <= 1'b1;
      out        <= result;
      out_zero   <= ~|result;
      out_parity <= ^result;
      op_count   <= op_count + CNT_W'(1);
    end else if (out_ready) begin
      out_valid  <= 1'b0;
    end
  end

  // Clear wins over the accept update; the op itself still saw the old acc.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      acc <= '0;
    else if (acc_clr)
      acc <= '0;
    else if (accept)
      acc <= result;
  end

endmodule

// File: tb/tb_logic_unit_pipe.sv
// Directed bench for logic_unit_pipe: reference model plus result scoreboard,
// with a CNT_W=4 instance for counter wrap.
module tb_logic_unit_pipe;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       in_valid = 1'b0, in_valid4 = 1'b0;
  logic       in_ready, in_ready4;
  logic [7:0] a = '0, b = '0;
  logic [2:0] sel = '0;
  logic       use_acc = 1'b0, acc_clr = 1'b0;
  logic       out_valid, out_valid4;
  logic       out_ready = 1'b1;
  logic [7:0] out, out4, acc, acc4;
  logic       out_zero, out_parity, out_zero4, out_parity4;
  logic [15:0] op_count;
  logic [3:0]  op_count4;

  always #5 clk = ~clk;

  logic_unit_pipe #(.WIDTH(8), .CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .sel(sel), .use_acc(use_acc), .acc_clr(acc_clr),
    .out_valid(out_valid), .out_ready(out_ready), .out(out),
    .out_zero(out_zero), .out_parity(out_parity), .acc(acc), .op_count(op_count)
  );

  logic_unit_pipe #(.WIDTH(8), .CNT_W(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid4), .in_ready(in_ready4),
    .a(a), .b(b), .sel(sel), .use_acc(1'b0), .acc_clr(1'b0),
    .out_valid(out_valid4), .out_ready(1'b1), .out(out4),
    .out_zero(out_zero4), .out_parity(out_parity4), .acc(acc4), .op_count(op_count4)
  );

  typedef struct packed {
    logic [7:0] o;
    logic       z;
    logic       p;
  } exp_t;

  exp_t        sb[$];
  logic        m_valid;
  logic [7:0]  m_acc;
  logic [15:0] m_cnt;
  int          n_assert = 0;
  int          n_fail = 0;

  function automatic logic [7:0] f(input logic [2:0] s, input logic [7:0] x, input logic [7:0] y);
    case (s)
      3'd0:    return ~x;
      3'd1:    return ~(x | y);
      3'd2:    return x & y;
      3'd3:    return x | y;
      3'd4:    return x ^ y;
      3'd5:    return ~(x ^ y);
      default: return ~(x & y);
    endcase
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock: pre-edge checks and model update, then post-edge state checks.
  task automatic cycle();
    logic       acc_now;
    logic [7:0] r;
    exp_t       e;
    #2;
    acc_now = in_valid && (!m_valid || out_ready);
    check("in_ready", in_ready, !m_valid || out_ready);
    if (m_valid) begin
      if (sb.size() == 0) begin
        check("sb_underflow", 1, 0);
      end else begin
        e = sb[0];
        check("out", out, e.o);
        check("out_zero", out_zero, e.z);
        check("out_parity", out_parity, e.p);
        if (out_ready) void'(sb.pop_front());
      end
    end
    if (acc_now) begin
      r = f(sel, a, use_acc ? m_acc : b);
      sb.push_back('{o: r, z: (r == 8'h00), p: ^r});
      m_cnt = m_cnt + 16'd1;
      m_valid = 1'b1;
    end else if (out_ready) begin
      m_valid = 1'b0;
    end
    if (acc_clr) m_acc = 8'h00;
    else if (acc_now) m_acc = r;
    @(posedge clk);
    #1;
    check("out_valid", out_valid, m_valid);
    check("acc", acc, m_acc);
    check("op_count", op_count, m_cnt);
  endtask

  task automatic model_reset();
    sb.delete();
    m_valid = 1'b0;
    m_acc = 8'h00;
    m_cnt = 16'd0;
  endtask

  task automatic op(input logic [2:0] s, input logic [7:0] x, input logic [7:0] y, input logic ua);
    in_valid = 1'b1; sel = s; a = x; b = y; use_acc = ua;
    cycle();
  endtask

  logic [7:0] tbl [8];

  initial begin
    tbl = '{8'h0F, 8'h05, 8'hA0, 8'hFA, 8'h5A, 8'hA5, 8'h5F, 8'h5F};
    model_reset();

    // Reset state
    #12;
    check("rst_out_valid", out_valid, 0);
    check("rst_out", out, 0);
    check("rst_out_zero", out_zero, 0);
    check("rst_out_parity", out_parity, 0);
    check("rst_acc", acc, 0);
    check("rst_op_count", op_count, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("rst_in_ready", in_ready, 1);

    // All eight operations back to back
    for (int i = 0; i < 8; i++) begin
      op(3'(i), 8'hF0, 8'hAA, 1'b0);
      check("op_table", out, tbl[i]);
      if (i == 4) check("parity_5a", out_parity, 0);
    end
    check("op_count_8", op_count, 8);

    op(3'd0, 8'hFF, 8'h00, 1'b0);
    check("zero_out", out, 8'h00);
    check("zero_flag", out_zero, 1);
    check("zero_parity", out_parity, 0);
    op(3'd3, 8'h01, 8'h00, 1'b0);
    check("one_out", out, 8'h01);
    check("one_flag", out_zero, 0);
    check("one_parity", out_parity, 1);

    // Accumulator chain
    in_valid = 1'b0; acc_clr = 1'b1;
    cycle();
    acc_clr = 1'b0;
    check("acc_clr_idle", acc, 8'h00);
    op(3'd3, 8'h01, 8'h55, 1'b1);
    check("chain1_out", out, 8'h01); check("chain1_acc", acc, 8'h01);
    op(3'd3, 8'h02, 8'h55, 1'b1);
    check("chain2_out", out, 8'h03); check("chain2_acc", acc, 8'h03);
    op(3'd4, 8'h80, 8'h55, 1'b1);
    check("chain3_out", out, 8'h83); check("chain3_acc", acc, 8'h83);
    acc_clr = 1'b1;
    op(3'd3, 8'h00, 8'h55, 1'b1);
    acc_clr = 1'b0;
    check("clr_accept_out", out, 8'h83); check("clr_accept_acc", acc, 8'h00);

    // Reset while a stalled result is pending
    out_ready = 1'b0;
    op(3'd4, 8'h12, 8'h34, 1'b0);
    op(3'd2, 8'h77, 8'h34, 1'b0);
    check("stall_before_rst", out_valid, 1);
    rst_n = 1'b0;
    #1;
    check("arst_out_valid", out_valid, 0);
    check("arst_out", out, 0);
    check("arst_acc", acc, 0);
    check("arst_op_count", op_count, 0);
    model_reset();
    in_valid = 1'b0; out_ready = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("post_rst_in_ready", in_ready, 1);
    for (int i = 0; i < 3; i++) cycle();

    // Backpressure: X accepted and held, Y waits
    out_ready = 1'b0;
    op(3'd2, 8'h3C, 8'h0F, 1'b0);
    check("bp_x_out", out, 8'h0C);
    sel = 3'd4;
    for (int i = 0; i < 5; i++) begin
      cycle();
      check("bp_x_hold", out, 8'h0C);
    end
    check("bp_in_ready", in_ready, 0);
    out_ready = 1'b1;
    cycle();
    check("bp_y_out", out, 8'h33);
    check("bp_op_count", op_count, 2);
    in_valid = 1'b0;
    cycle();

    // CNT_W=4 wrap
    in_valid4 = 1'b1;
    for (int i = 0; i < 17; i++) @(posedge clk);
    #1;
    in_valid4 = 1'b0;
    check("cnt4_wrap", op_count4, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/logic_unit_pipe.md
Name: logic_unit_pipe

Overview:
- Parametrised, registered successor of the 1-bit universal-gate function selector.
- Applies one of eight bitwise logic operations to WIDTH-bit operands.
- Operand B can come either from the input port or from an internal accumulator, so operations can be chained.
- Input and output use valid/ready handshakes with one register slice, and the block counts completed operations; it sits between datapath sources and a downstream consumer that may stall.

Parameters:
- WIDTH, 8, operand/result width in bits (>=1).
- CNT_W, 16, width of the accepted-operation counter.

Ports:
- clk  input  1  clock, all state updates on rising edge
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  operands and sel are valid
- in_ready  output  1  block can accept this cycle
- a  input  WIDTH  operand A
- b  input  WIDTH  operand B (ignored when use_acc=1)
- sel  input  3  operation select
- use_acc  input  1  1: operand B := accumulator
- acc_clr  input  1  synchronous accumulator clear
- out_valid  output  1  result valid
- out_ready  input  1  consumer accepts result
- out  output  WIDTH  registered result
- out_zero  output  1  registered: result == 0
- out_parity  output  1  registered: XOR-reduction of result
- acc  output  WIDTH  current accumulator value
- op_count  output  CNT_W  number of accepted operations, wraps

Behaviour:
- Reset is asynchronous, active-low (rst_n=0). During reset:
  - out_valid=0, out=0, out_zero=0, out_parity=0, acc=0, op_count=0.
  - in_ready=1 once reset releases.
- Operation encoding, with B_eff = use_acc ? acc : b:
  - 0 = ~a (B ignored)
  - 1 = ~(a|B_eff)
  - 2 = a&B_eff
  - 3 = a|B_eff
  - 4 = a^B_eff
  - 5 = ~(a^B_eff)
  - 6 = ~(a&B_eff)
  - 7 = ~(a&B_eff), a NAND duplicate kept for encoding compatibility with the 1-bit selector.
- in_ready = !out_valid || out_ready. It is combinational with no dependence on in_valid.
- Accept = in_valid && in_ready. On accept, at the next edge:
  - out <= f(sel, a, B_eff), with out_zero and out_parity computed from that same result.
  - out_valid <= 1.
- Latency is 1 cycle from accept to out_valid. Throughput is 1 op per cycle while out_ready=1.
- If out_valid && out_ready && !accept, then out_valid <= 0. out, out_zero and out_parity hold their last values.
- While out_valid && !out_ready: out, out_zero, out_parity and out_valid are stable, in_ready=0, and no accept occurs.
- Accumulator:
  - On every accept, acc <= result, regardless of use_acc.
  - acc_clr=1 sets acc <= 0 at the next edge and takes priority over an accept-update.
  - If acc_clr coincides with an accept that has use_acc=1, the operation uses the pre-clear acc value; acc still ends at 0.
  - acc_clr acts even when no accept occurs.
- op_count increments by 1 on each accept and wraps from 2^CNT_W-1 to 0. It is not affected by acc_clr.
- sel, a, b and use_acc are sampled only on accept. Their values when in_valid=0 are don't-care.
- Reset asserted mid-stream: any pending result is discarded immediately, out_valid=0, all state returns to reset values. After release there are no spurious output beats.
- WIDTH=1 must behave as the legacy 1-bit selector, with registered output.

Test Plan:
- WIDTH=8, out_ready=1, b=8'hAA, a=8'hF0:
  - sel 0/1/2/3/4/5/6/7 on consecutive cycles -> out 0F/05/A0/FA/5A/A5/5F/5F.
  - Each out appears one cycle after its accept.
  - out_parity for 5A = 0; op_count = 8.
- a=8'hFF, sel=0 -> out=00, out_zero=1, out_parity=0.
  - Next: a=8'h01, b=8'h00, sel=3 -> out=01, out_zero=0, out_parity=1.
- Accumulate: acc_clr pulse -> acc=00. Then, with use_acc=1:
  - sel=3, a=01 -> out=01, acc=01.
  - sel=3, a=02 -> out=03, acc=03.
  - sel=4, a=80 -> out=83, acc=83.
  - acc_clr together with accept (use_acc=1, sel=3, a=00) -> out=83, acc=00.
- Backpressure: out_ready=0, in_valid=1 with ops X then Y:
  - X accepted, in_ready=0 the next cycle.
  - X output is held stable for 5 cycles and Y is not accepted.
  - Raise out_ready -> X consumed, Y accepted that same cycle, Y appears next cycle; op_count = 2.
- CNT_W=4: 17 accepts -> op_count=1.
- Reset mid-stream: assert rst_n=0 while out_valid=1 and out_ready=0.
  - Outputs clear asynchronously (before the next clk edge), acc=0, op_count=0.
  - After release, in_ready=1 and out_valid stays 0 until a new accept.
